hilo_divider: RTL and testbench



---
 rtl/hilo_divider_if.sv | 34 +++
 rtl/hilo_divider.sv | 170 +++++++++++++++++
 tb/tb_hilo_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hilo_divider_if                                                  |
// | Purpose  : Request/result bundle between pipeline control and the HI/LO    |
// |            divider.                                                         |
// | Signals  : start, is_signed, dividend, divisor  (control -> divider)        |
// |            busy, done, quotient, remainder, div_by_zero (divider -> control)|
// | Modports : master (pipeline control), slave (divider)                      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/hilo_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hilo_divider                                                     |
// | Purpose  : Iterative restoring divider for MIPS DIV/DIVU. One trial        |
// |            subtraction per clock, quotient to LO, remainder to HI.         |
// | Ports    : clk        - system clock, rising edge                          |
// |            rst_n      - asynchronous active-low reset                      |
// |            div_if     - hilo_divider_if.slave (start/operands in,          |
// |                         busy/done/quotient/remainder/div_by_zero out)      |
// | Options  : HILO_DIV_ZERO_FAST_EN - when defined, a zero divisor skips the  |
// |            iteration phase and completes one cycle after acceptance.      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  hilo_divider_if.slave  div_if
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] prem_q,     prem_d;      // partial remainder
  logic [WIDTH-1:0] quo_q,      quo_d;       // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q,      dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;  // un-negated dividend for divide-by-zero
  logic             neg_quo_q,  neg_quo_d;
  logic             neg_rem_q,  neg_rem_d;
  logic             zero_q,     zero_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q,  rem_out_d;
  logic             dbz_q,      dbz_d;
  logic             done_q,     done_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Magnitudes of the incoming operands; unsigned mode passes them through.
  assign dvd_mag = (div_if.is_signed && div_if.dividend[WIDTH-1]) ? (~div_if.dividend + 1'b1)
                                                                   : div_if.dividend;
  assign dvs_mag = (div_if.is_signed && div_if.divisor[WIDTH-1])  ? (~div_if.divisor + 1'b1)
                                                                   : div_if.divisor;

  // One restoring step: bring in the next dividend bit, then try a subtract.
  // The extra top bit of trial is the borrow.
  assign shifted = {prem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dvd_orig_d = dvd_orig_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (div_if.start) begin
          quo_d      = dvd_mag;
          dvs_d      = dvs_mag;
          dvd_orig_d = div_if.dividend;
          prem_d     = '0;
          cnt_d      = '0;
          neg_quo_d  = div_if.is_signed & (div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1]);
          neg_rem_d  = div_if.is_signed & div_if.dividend[WIDTH-1];
          zero_d     = (div_if.divisor == '0);
`ifdef HILO_DIV_ZERO_FAST_EN
          state_d    = (div_if.divisor == '0) ? FIX : RUN;
`else
          state_d    = RUN;
`endif
        end
      end

      RUN: begin
        if (!trial[WIDTH]) begin
          prem_d = trial[WIDTH-1:0];
          quo_d  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH-1:0];
          quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // A zero divisor reports the architectural fixed values and skips
        // the sign correction, so it behaves the same with or without RUN.
        if (zero_q) begin
          quot_out_d = '1;
          rem_out_d  = dvd_orig_q;
          dbz_d      = 1'b1;
        end else begin
          quot_out_d = neg_quo_q ? (~quo_q + 1'b1)  : quo_q;
          rem_out_d  = neg_rem_q ? (~prem_q + 1'b1) : prem_q;
          dbz_d      = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_orig_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dvd_orig_q <= dvd_orig_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  assign div_if.busy        = (state_q != IDLE);
  assign div_if.done        = done_q;
  assign div_if.quotient    = quot_out_q;
  assign div_if.remainder   = rem_out_q;
  assign div_if.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hilo_divider                                                  |
// | Purpose  : Self-checking bench for hilo_divider (WIDTH=32) against a       |
// |            64-bit arithmetic reference model.                              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_hilo_divider;

  localparam int W = 32;
`ifdef HILO_DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif
  localparam int NZ_LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hilo_divider_if #(.WIDTH(W)) dif ();

  hilo_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  // Reference: quotient truncates toward zero, remainder takes the dividend's
  // sign; 64-bit arithmetic keeps the most-negative / -1 case well defined.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint as, bs;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s) begin
      as = longint'($signed(a));
      bs = longint'($signed(b));
      q  = 32'(as / bs);
      r  = 32'(as % bs);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issues one operation and waits (bounded) for done. lat = -1 on timeout.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic z, output logic busy_ok);
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = s; dif.dividend = a; dif.divisor = b;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom;
    dif.is_signed = 1'($urandom);
    busy_ok = dif.busy;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (dif.done) begin lat = k; break; end
      if (!dif.busy) busy_ok = 1'b0;
    end
    q = dif.quotient; r = dif.remainder; z = dif.div_by_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] q, r; logic z, bo;
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, z, bo);
    total++; if (lat !== NZ_LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, NZ_LAT); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL basic_busy: busy dropped before done"); end
    total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", dif.busy); end
    total++; if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      bad++; $display("FAIL basic_result: got q=%0d r=%0d z=%b want q=14 r=2 z=0", q, r, z);
    end
    @(posedge clk); #1;
    total++; if (dif.done !== 1'b0 || dif.quotient !== 32'd14) begin
      bad++; $display("FAIL basic_pulse_hold: got done=%b q=%0d want done=0 q=14", dif.done, dif.quotient);
    end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] q, r; logic z, bo;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, q, r, z, bo);
    total++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || z !== 1'b0) begin
      bad++; $display("FAIL div_neg7_2: got q=%h r=%h z=%b want q=fffffffd r=ffffffff z=0", q, r, z);
    end
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, q, r, z, bo);
    total++; if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
      bad++; $display("FAIL divu_fff9_2: got q=%h r=%h want q=7ffffffc r=1", q, r);
    end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, z, bo);
    total++; if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0 || lat !== NZ_LAT) begin
      bad++; $display("FAIL div_overflow: got q=%h r=%h z=%b lat=%0d want q=80000000 r=0 z=0 lat=%0d",
                      q, r, z, lat, NZ_LAT);
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] q, r; logic z, bo;
    run_op(1'b0, 32'd5, 32'd0, lat, q, r, z, bo);
    total++; if (q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1) begin
      bad++; $display("FAIL divu_zero: got q=%h r=%h z=%b want q=ffffffff r=5 z=1", q, r, z);
    end
    total++; if (lat !== ZERO_LAT) begin bad++; $display("FAIL divu_zero_latency: got %0d want %0d", lat, ZERO_LAT); end
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, q, r, z, bo);
    total++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || z !== 1'b1) begin
      bad++; $display("FAIL div_zero: got q=%h r=%h z=%b want q=ffffffff r=fffffffb z=1", q, r, z);
    end
    total++; if (lat !== ZERO_LAT) begin bad++; $display("FAIL div_zero_latency: got %0d want %0d", lat, ZERO_LAT); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 9)  begin dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3; end
      if (k == 10) dif.start = 1'b0;
      if (dif.done) begin lat = k; break; end
    end
    total++; if (lat !== NZ_LAT || dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
      bad++; $display("FAIL ignore_busy_start: got lat=%0d q=%0d r=%0d want lat=%0d q=14 r=2",
                      lat, dif.quotient, dif.remainder, NZ_LAT);
    end
    // Issue the next operation while done is still high.
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd9; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (dif.done) begin lat = k; break; end
    end
    total++; if (lat !== NZ_LAT || dif.quotient !== 32'd3 || dif.remainder !== 32'd0) begin
      bad++; $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d want lat=%0d q=3 r=0",
                      lat, dif.quotient, dif.remainder, NZ_LAT);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] a, b, q, r, eq, er; logic s, z, ez, bo;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, eq, er, ez);
      run_op(s, a, b, lat, q, r, z, bo);
      total++; if (q !== eq || r !== er || z !== ez) begin
        bad++; $display("FAIL random_%0d s=%b a=%h b=%h: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                        i, s, a, b, q, r, z, eq, er, ez);
      end
      total++; if (lat !== ((b == 32'd0) ? ZERO_LAT : NZ_LAT)) begin
        bad++; $display("FAIL random_latency_%0d: got %0d want %0d", i, lat,
                        (b == 32'd0) ? ZERO_LAT : NZ_LAT);
      end
    end
  endtask

  task automatic test_async_reset;
    int lat; logic [31:0] q, r; logic z, bo, saw_done;
    // Leave a non-zero result and the zero flag set so clearing is visible.
    run_op(1'b0, 32'd77, 32'd0, lat, q, r, z, bo);
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'h1234_5678; dif.divisor = 32'h1111;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (dif.done || dif.busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got activity=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
